// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the I/D-cache fill and write-through memory arbiter.
// State encodings and block geometry defaults.
package cache_mem_arbiter_pkg;

  localparam int BLK_WORDS    = 8;
  localparam int BLK_OFFSET_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL_I = 2'd1,
    S_FILL_D = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

endpackage

// File: rtl/cache_mem_arbiter_blk_word_counter.sv
// Word counter for one block transfer: synchronous clear has priority over enable.
// Zero latency on the terminal flag; no backpressure, advances only when enabled.
module blk_word_counter #(
  parameter int W    = 4,
  parameter int TERM = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         done
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign done = (cnt == W'(TERM));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I/D-cache block fills and D-cache write-through stores onto one pipelined memory.
// First read 1 cycle after acceptance, 8 reads back-to-back; losers hold their level request until served.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = BLK_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_vld,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_grant,
  output logic              d_data_vld,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata_in,
  input  logic              mem_vld,
  output logic [DATA_W-1:0] mem_rdata
);

  localparam int                CNT_W     = $clog2(WORDS_PER_BLK) + 1;
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_BLK - 1);
  localparam logic [ADDR_W-1:0] OFS_MASK  = ADDR_W'((1 << BLK_OFFSET_W) - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [CNT_W-1:0]  issue_cnt, ret_cnt;
  logic              issue_done, ret_done;
  logic              issue_en, ret_en, cnt_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      base  <= '0;
    end else begin
      state <= state_nxt;
      base  <= base_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    base_nxt   = base;
    issue_en   = 1'b0;
    ret_en     = 1'b0;
    i_grant    = 1'b0;
    d_grant    = 1'b0;
    i_data_vld = 1'b0;
    d_data_vld = 1'b0;
    d_wr_ack   = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      S_IDLE: begin
        if (d_wr_req) begin
          state_nxt = S_WRITE;
        end else if (d_miss) begin
          state_nxt = S_FILL_D;
          base_nxt  = d_addr & ~OFS_MASK;
        end else if (i_miss) begin
          state_nxt = S_FILL_I;
          base_nxt  = i_addr & ~OFS_MASK;
        end
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_FILL_I, S_FILL_D: begin
        i_grant = (state == S_FILL_I);
        d_grant = (state == S_FILL_D);
        if (!issue_done) begin
          mem_en   = 1'b1;
          issue_en = 1'b1;
          // Word offset is masked into the block so the walk never carries into the tag.
          mem_addr = base | (ADDR_W'({issue_cnt, 1'b0}) & OFS_MASK);
        end
        if (mem_vld && !ret_done) begin
          ret_en     = 1'b1;
          i_data_vld = (state == S_FILL_I);
          d_data_vld = (state == S_FILL_D);
          if (ret_cnt == LAST_WORD) begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    cnt_clr = (state_nxt == S_IDLE);
  end

  assign mem_rdata = mem_rdata_in;

  blk_word_counter #(.W(CNT_W), .TERM(WORDS_PER_BLK)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (issue_en),
    .cnt   (issue_cnt),
    .done  (issue_done)
  );

  blk_word_counter #(.W(CNT_W), .TERM(WORDS_PER_BLK)) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (ret_en),
    .cnt   (ret_cnt),
    .done  (ret_done)
  );

endmodule
